// File: rtl/swc_sequencer_if.sv
// Host/Swc-facing signal bundle of the Swc instruction sequencer.
// The slave modport is the sequencer; the master side holds the host request lines and the Swc ready line.
interface swc_sequencer_if;
    logic        start;
    logic [1:0]  mode;
    logic [23:0] value;
    logic        abort;
    logic        swc_ready;
    logic [11:0] inst;
    logic        inst_en;
    logic        busy;
    logic        done;
    logic        aborted;

    modport master (
        output start, mode, value, abort, swc_ready,
        input  inst, inst_en, busy, done, aborted
    );

    modport slave (
        input  start, mode, value, abort, swc_ready,
        output inst, inst_en, busy, done, aborted
    );
endinterface

// File: rtl/swc_sequencer.sv
// Turns one host request into the Swc sequence LD0/LD1/LD2 [+ CCD/CCU, wait, optional CCS abort].
// Every output is a flop, decoded from the next state so it lines up with the state it belongs to.
module swc_sequencer (
    input  logic           clock,
    input  logic           reset,
    swc_sequencer_if.slave bus
);

    localparam logic [3:0] OP_LD0 = 4'h1;
    localparam logic [3:0] OP_LD1 = 4'h2;
    localparam logic [3:0] OP_LD2 = 4'h3;
    localparam logic [3:0] OP_CCU = 4'h6;
    localparam logic [3:0] OP_CCD = 4'h7;
    localparam logic [3:0] OP_CCS = 4'h8;

    localparam logic [1:0] MODE_CCD = 2'd1;
    localparam logic [1:0] MODE_CCU = 2'd2;

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_LD0,
        S_LD1,
        S_LD2,
        S_RUN,
        S_WAIT,
        S_STOP,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [23:0] value_q;
    logic [23:0] value_nx;
    logic [1:0]  mode_q;
    logic [1:0]  mode_nx;
    logic [11:0] inst_nx;
    logic        inst_en_nx;
    logic        busy_nx;
    logic        done_nx;
    logic        aborted_nx;
    logic        count_mode;

    assign count_mode = (mode_q == MODE_CCD) || (mode_q == MODE_CCU);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_nx   = state;
        value_nx   = value_q;
        mode_nx    = mode_q;
        aborted_nx = 1'b0;

        unique case (state)
            S_INIT: state_nx = S_IDLE;
            S_IDLE: begin
                if (bus.start) begin
                    state_nx = S_LD0;
                    value_nx = bus.value;
                    mode_nx  = bus.mode;
                end
            end
            S_LD0: state_nx = S_LD1;
            S_LD1: state_nx = S_LD2;
            // A zero count would run the full 2^24 wrap, so it finishes as a plain load.
            S_LD2: state_nx = (count_mode && (value_q != 24'd0)) ? S_RUN : S_DONE;
            S_RUN: state_nx = S_WAIT;
            S_WAIT: begin
                if (bus.swc_ready) begin
                    state_nx = S_DONE;
                end else if (bus.abort) begin
                    state_nx = S_STOP;
                end
            end
            S_STOP: begin
                state_nx   = S_DONE;
                aborted_nx = 1'b1;
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_INIT;
        endcase

        inst_nx    = 12'h000;
        inst_en_nx = 1'b0;
        done_nx    = (state_nx == S_DONE);
        busy_nx    = (state_nx != S_IDLE);
        unique case (state_nx)
            S_LD0:  inst_nx = {OP_LD0, value_nx[7:0]};
            S_LD1:  inst_nx = {OP_LD1, value_nx[15:8]};
            S_LD2:  inst_nx = {OP_LD2, value_nx[23:16]};
            S_RUN:  inst_nx = {(mode_nx == MODE_CCU) ? OP_CCU : OP_CCD, 8'h00};
            S_STOP: inst_nx = {OP_CCS, 8'h00};
            default: inst_nx = 12'h000;
        endcase
        inst_en_nx = (state_nx == S_LD0) || (state_nx == S_LD1) || (state_nx == S_LD2) ||
                     (state_nx == S_RUN) || (state_nx == S_STOP);
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state       <= S_INIT;
            value_q     <= 24'd0;
            mode_q      <= 2'd0;
            bus.inst    <= 12'h000;
            bus.inst_en <= 1'b0;
            bus.busy    <= 1'b1;
            bus.done    <= 1'b0;
            bus.aborted <= 1'b0;
        end else begin
            state       <= state_nx;
            value_q     <= value_nx;
            mode_q      <= mode_nx;
            bus.inst    <= inst_nx;
            bus.inst_en <= inst_en_nx;
            bus.busy    <= busy_nx;
            bus.done    <= done_nx;
            bus.aborted <= aborted_nx;
        end
    end

endmodule

// File: tb/tb_swc_sequencer.sv
// Scoreboard bench for swc_sequencer with a behavioural Swc counter model driving swc_ready.
// Stimulus pushes expected inst/done events; a negedge monitor pops and compares them.
module tb_swc_sequencer;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    swc_sequencer_if bus();

    swc_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Swc model: byte loads, continuous count that halts at zero, CCS freezes, ignores the post-reset cycle.
    logic [23:0] swc_cnt;
    logic        swc_counting;
    logic        swc_up;
    logic        swc_skip;

    always @(posedge clock) begin
        if (reset) begin
            swc_cnt      <= 24'd0;
            swc_counting <= 1'b0;
            swc_up       <= 1'b0;
            swc_skip     <= 1'b1;
        end else begin
            swc_skip <= 1'b0;
            if (!swc_skip && bus.inst_en) begin
                case (bus.inst[11:8])
                    4'h1: swc_cnt[7:0]   <= bus.inst[7:0];
                    4'h2: swc_cnt[15:8]  <= bus.inst[7:0];
                    4'h3: swc_cnt[23:16] <= bus.inst[7:0];
                    4'h6: begin swc_counting <= 1'b1; swc_up <= 1'b1; swc_cnt <= swc_cnt + 24'd1; end
                    4'h7: begin swc_counting <= 1'b1; swc_up <= 1'b0; swc_cnt <= swc_cnt - 24'd1; end
                    4'h8: swc_counting <= 1'b0;
                    default: ;
                endcase
            end else if (swc_counting) begin
                if (swc_cnt == 24'd0) swc_counting <= 1'b0;
                else                  swc_cnt <= swc_up ? swc_cnt + 24'd1 : swc_cnt - 24'd1;
            end
        end
    end

    assign bus.swc_ready = (swc_cnt == 24'd0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        bit          is_done;
        logic [11:0] inst;
        bit          aborted;
        int          at_cyc;
        logic [23:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic push_inst(input logic [11:0] i, input int c);
        exp_t e;
        e.is_done = 1'b0; e.inst = i; e.aborted = 1'b0; e.at_cyc = c; e.cnt = 24'd0;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input bit ab, input int c, input logic [23:0] cnt);
        exp_t e;
        e.is_done = 1'b1; e.inst = 12'h000; e.aborted = ab; e.at_cyc = c; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: every inst_en or done cycle must match the head of the scoreboard.
    always @(negedge clock) begin
        if (bus.inst_en || bus.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'({bus.done, bus.inst_en}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("output_kind", 32'(bus.done), 32'(mon_e.is_done));
                check("output_cycle", cyc, mon_e.at_cyc);
                if (mon_e.is_done) begin
                    check("aborted", 32'(bus.aborted), 32'(mon_e.aborted));
                    check("busy_at_done", 32'(bus.busy), 32'd1);
                    check("swc_counter", 32'(swc_cnt), 32'(mon_e.cnt));
                end else begin
                    check("inst", 32'(bus.inst), 32'(mon_e.inst));
                end
            end
        end else if (bus.inst != 12'h000) begin
            check("inst_zero_when_idle", 32'(bus.inst), 32'd0);
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic issue(input logic [1:0] m, input logic [23:0] v, output int k);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!bus.busy) break;
        end
        check("busy_low_before_start", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.value = v;
        @(posedge clock);
        #1;
        k = cyc;
        bus.start = 1'b0;
        bus.mode  = ~m;
        bus.value = ~v;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clock);
        end
        check("drain_timeout", exp_q.size(), 32'd0);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 2'd0;
        bus.value = 24'd0;
        bus.abort = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_inst", 32'(bus.inst), 32'd0);
        check("reset_inst_en", 32'(bus.inst_en), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_aborted", 32'(bus.aborted), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_after_init", 32'(bus.busy), 32'd0);

        // Load only.
        issue(2'd0, 24'hABCDEF, k);
        push_inst(12'h1EF, k); push_inst(12'h2CD, k + 1); push_inst(12'h3AB, k + 2);
        push_done(1'b0, k + 3, 24'hABCDEF);
        drain(40);

        // CCD of 5; abort during the load phase must be ignored.
        issue(2'd1, 24'h000005, k);
        push_inst(12'h105, k); push_inst(12'h200, k + 1); push_inst(12'h300, k + 2);
        push_inst(12'h700, k + 3); push_done(1'b0, k + 9, 24'h000000);
        wait_cyc(k + 1); bus.abort = 1'b1;
        wait_cyc(k + 3); bus.abort = 1'b0;
        drain(40);

        // CCU wraps from FFFFFD to zero in three steps.
        issue(2'd2, 24'hFFFFFD, k);
        push_inst(12'h1FD, k); push_inst(12'h2FF, k + 1); push_inst(12'h3FF, k + 2);
        push_inst(12'h600, k + 3); push_done(1'b0, k + 7, 24'h000000);
        drain(40);

        // Zero value with a count mode skips the CCx.
        issue(2'd1, 24'h000000, k);
        push_inst(12'h100, k); push_inst(12'h200, k + 1); push_inst(12'h300, k + 2);
        push_done(1'b0, k + 3, 24'h000000);
        drain(40);

        // Mode 3 behaves as load only.
        issue(2'd3, 24'h000042, k);
        push_inst(12'h142, k); push_inst(12'h200, k + 1); push_inst(12'h300, k + 2);
        push_done(1'b0, k + 3, 24'h000042);
        drain(40);

        // Abort in the 10th WAIT cycle: CCD takes effect on edge k+4 (FF), 11 decrements by the CCS edge -> F5.
        issue(2'd1, 24'h000100, k);
        push_inst(12'h100, k); push_inst(12'h201, k + 1); push_inst(12'h300, k + 2);
        push_inst(12'h700, k + 3); push_inst(12'h800, k + 14);
        push_done(1'b1, k + 15, 24'h0000F5);
        wait_cyc(k + 6);
        bus.start = 1'b1; bus.mode = 2'd0; bus.value = 24'h123456;
        wait_cyc(k + 7);
        bus.start = 1'b0;
        wait_cyc(k + 13); bus.abort = 1'b1;
        wait_cyc(k + 14); bus.abort = 1'b0;
        drain(40);
        check("aborted_cleared", 32'(bus.aborted), 32'd0);

        // Ready and abort together: completion wins (counter hits 0 in cycle k+6).
        issue(2'd1, 24'h000003, k);
        push_inst(12'h103, k); push_inst(12'h200, k + 1); push_inst(12'h300, k + 2);
        push_inst(12'h700, k + 3); push_done(1'b0, k + 7, 24'h000000);
        wait_cyc(k + 6); bus.abort = 1'b1;
        wait_cyc(k + 7); bus.abort = 1'b0;
        drain(40);

        // Reset during LD1, then a fresh request.
        issue(2'd1, 24'h000010, k);
        push_inst(12'h110, k); push_inst(12'h200, k + 1);
        wait_cyc(k + 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midreset_inst_en", 32'(bus.inst_en), 32'd0);
        check("midreset_busy", 32'(bus.busy), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("midreset_idle", 32'(bus.busy), 32'd0);
        issue(2'd1, 24'h000003, k);
        push_inst(12'h103, k); push_inst(12'h200, k + 1); push_inst(12'h300, k + 2);
        push_inst(12'h700, k + 3); push_done(1'b0, k + 7, 24'h000000);
        drain(40);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
